// File: rtl/temp_sensor_spi_reader.sv
`default_nettype none
// ============================================================================
// Module      : temp_sensor_spi_reader
// Description : Periodically polls an LM74-style SPI temperature sensor and
//               presents the 13-bit two's-complement temperature (0.0625 C
//               per LSB) to the downstream temperature PIO input port.
//               Each poll is one chip-select frame of FRAME_BITS SCK periods.
//               The frame start-to-start period is POLL_CYCLES clk while
//               enable is held high.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   system clock
//   reset      in   1   asynchronous active-high reset
//   enable     in   1   polling enable (level)
//   spi_sck    out  1   sensor serial clock, idles low
//   spi_cs_n   out  1   sensor chip select, active low
//   spi_miso   in   1   sensor serial data (asynchronous to clk)
//   temp_out   out  13  latest temperature, two's complement
//   temp_valid out  1   one-clk pulse in the cycle temp_out takes a new value
//   busy       out  1   high while spi_cs_n is low
// ----------------------------------------------------------------------------
// Build option
//   TEMP_AVG_EN : when defined, temp_out is the running average of the last
//                 four samples (history starts at zero after reset).
// ============================================================================
module temp_sensor_spi_reader #(
    parameter int CLK_DIV     = 25,
    parameter int POLL_CYCLES = 5000000,
    parameter int FRAME_BITS  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        spi_sck,
    output logic        spi_cs_n,
    input  logic        spi_miso,
    output logic [12:0] temp_out,
    output logic        temp_valid,
    output logic        busy
);

    localparam int c_div_w  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_bit_w  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int c_poll_w = $clog2(POLL_CYCLES);

    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(FRAME_BITS - 1);
    localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_UPDATE   = 3'd4,
        ST_WAIT     = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [c_div_w-1:0]      r_div;
    logic [c_div_w-1:0]      w_div_next;
    logic [c_bit_w-1:0]      r_bit;
    logic [c_bit_w-1:0]      w_bit_next;
    logic                    r_hi;
    logic                    w_hi_next;
    logic [c_poll_w-1:0]     r_poll;

    logic                    r_sync1;
    logic                    r_sync2;
    logic [FRAME_BITS-1:0]   r_shift;

    logic                    r_sck;
    logic                    r_cs_n;
    logic [12:0]             r_temp;
    logic                    r_valid;

    logic                    w_div_end;
    logic                    w_sck_next;
    logic                    w_cs_n_next;
    logic                    w_frame_start;
    logic                    w_sample;
    logic                    w_load;
    logic [12:0]             w_raw;
    logic [12:0]             w_temp_new;

    assign w_div_end = (r_div == c_div_last);
    assign w_raw     = r_shift[FRAME_BITS-1 -: 13];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and phase-counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_hi_next    = r_hi;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_CS_SETUP;
                    w_div_next   = '0;
                end
            end
            ST_CS_SETUP: begin
                if (w_div_end) begin
                    w_state_next = ST_SHIFT;
                    w_div_next   = '0;
                    w_hi_next    = 1'b0;
                    w_bit_next   = '0;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_div_end) begin
                    w_div_next = '0;
                    if (!r_hi) begin
                        w_hi_next = 1'b1;
                    end else begin
                        w_hi_next = 1'b0;
                        if (r_bit == c_bit_last) begin
                            w_state_next = ST_CS_HOLD;
                        end else begin
                            w_bit_next = r_bit + 1'b1;
                        end
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            ST_CS_HOLD: begin
                if (w_div_end) begin
                    w_state_next = ST_UPDATE;
                    w_div_next   = '0;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            ST_UPDATE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_poll == c_poll_last) begin
                    w_state_next = enable ? ST_CS_SETUP : ST_IDLE;
                    w_div_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Pin levels are derived from the next state and registered, so the
    // pins are glitch-free and reset drives them to idle immediately.
    always_comb begin
        w_sck_next    = (w_state_next == ST_SHIFT) && w_hi_next;
        w_cs_n_next   = !((w_state_next == ST_CS_SETUP) ||
                          (w_state_next == ST_SHIFT)    ||
                          (w_state_next == ST_CS_HOLD));
        w_frame_start = (w_state_next == ST_CS_SETUP) && (r_state != ST_CS_SETUP);
        // Capture on the first clk of each high phase: r_sync2 then holds
        // the pin level from just before the rising SCK edge, which the
        // sensor last changed a full low phase (CLK_DIV clk) earlier.
        w_sample      = (r_state == ST_SHIFT) && r_hi && (r_div == '0);
        w_load        = (r_state == ST_CS_HOLD) && w_div_end;
    end

    // ------------------------------------------------------------------
    // MISO synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= spi_miso;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: counters, pins, shift register, output word
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_hi    <= 1'b0;
            r_poll  <= '0;
            r_sck   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_shift <= '0;
            r_temp  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_hi    <= w_hi_next;
            r_sck   <= w_sck_next;
            r_cs_n  <= w_cs_n_next;
            r_valid <= w_load;

            // Poll counter restarts at each frame start and saturates, so
            // the WAIT exit condition stays true once reached.
            if (w_frame_start) begin
                r_poll <= '0;
            end else if ((r_state != ST_IDLE) && (r_poll != c_poll_last)) begin
                r_poll <= r_poll + 1'b1;
            end

            // MSB first: the first bit received ends up in the sign position.
            if (w_sample) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], r_sync2};
            end

            if (w_load) begin
                r_temp <= w_temp_new;
            end
        end
    end

`ifdef TEMP_AVG_EN
    // ------------------------------------------------------------------
    // Four-sample running average. The sum is maintained incrementally
    // (add newest, drop oldest) and the arithmetic shift rounds toward
    // minus infinity.
    // ------------------------------------------------------------------
    logic signed [12:0] r_hist [4];
    logic signed [14:0] r_sum;
    logic signed [14:0] w_sum_next;

    assign w_sum_next = r_sum + {{2{w_raw[12]}}, w_raw}
                              - {{2{r_hist[3][12]}}, r_hist[3]};
    assign w_temp_new = 13'(w_sum_next >>> 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= '0;
            end
            r_sum <= '0;
        end else if (w_load) begin
            r_hist[0] <= w_raw;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
            r_hist[3] <= r_hist[2];
            r_sum     <= w_sum_next;
        end
    end
`else
    assign w_temp_new = w_raw;
`endif

    assign spi_sck    = r_sck;
    assign spi_cs_n   = r_cs_n;
    assign busy       = ~r_cs_n;
    assign temp_out   = r_temp;
    assign temp_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_temp_sensor_spi_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_temp_sensor_spi_reader
// Description : Self-checking bench for temp_sensor_spi_reader. A sensor
//               model answers each chip-select frame with a planned or
//               random word; the expected temperature is queued at frame
//               start and a monitor compares it on every temp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_sensor_spi_reader;

    localparam int CLK_DIV     = 2;
    localparam int POLL_CYCLES = 200;
    localparam int FRAME_BITS  = 16;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_miso;
    logic [12:0] temp_out;
    logic        temp_valid;
    logic        busy;

    temp_sensor_spi_reader #(
        .CLK_DIV     (CLK_DIV),
        .POLL_CYCLES (POLL_CYCLES),
        .FRAME_BITS  (FRAME_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_miso   (spi_miso),
        .temp_out   (temp_out),
        .temp_valid (temp_valid),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [12:0] sb_q[$];
    logic [15:0] plan_q[$];
    int          model_hist[$];
    int          vtimes[$];
    logic [12:0] last_exp = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        model_hist.delete();
        for (int i = 0; i < 4; i++) model_hist.push_back(0);
    endtask

    // Reference: raw frame bits [15:3], optionally floored mean of last 4.
    function automatic logic [12:0] model_next(input logic [15:0] word);
        int s;
        s = $signed(word[15:3]);
`ifdef TEMP_AVG_EN
        begin
            int sum;
            int avg;
            model_hist.push_back(s);
            void'(model_hist.pop_front());
            sum = 0;
            foreach (model_hist[i]) sum += model_hist[i];
            avg = (sum >= 0) ? (sum / 4) : -((-sum + 3) / 4);
            return 13'(avg);
        end
`else
        return 13'(s);
`endif
    endfunction

    // Sensor model: first bit valid when CS falls, next bit after each
    // falling SCK; a CS rise aborts the frame.
    initial begin
        logic [15:0] word;
        int          idx;
        spi_miso = 1'b0;
        forever begin
            @(negedge spi_cs_n);
            if (plan_q.size() > 0) word = plan_q.pop_front();
            else                   word = 16'($urandom);
            sb_q.push_back(model_next(word));
            idx      = 15;
            spi_miso = word[idx];
            forever begin
                @(negedge spi_sck or posedge spi_cs_n);
                if (spi_cs_n) break;
                if (idx > 0) begin
                    idx--;
                    spi_miso = word[idx];
                end
            end
        end
    end

    // Monitor: pin protocol and scoreboard comparison.
    initial begin
        int   low_cnt  = 0;
        int   rise_cnt = 0;
        logic prev_sck = 1'b0;
        logic prev_cs  = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                low_cnt  = 0;
                rise_cnt = 0;
                prev_sck = 1'b0;
                prev_cs  = 1'b1;
            end else begin
                check("busy_vs_cs", busy, !spi_cs_n);
                if (!spi_cs_n) begin
                    low_cnt++;
                    if (spi_sck && !prev_sck) rise_cnt++;
                end else begin
                    check("sck_idle_low", spi_sck, 1'b0);
                    if (!prev_cs) begin
                        check("cs_low_cycles", low_cnt, 34 * CLK_DIV);
                        check("sck_rises", rise_cnt, FRAME_BITS);
                        low_cnt  = 0;
                        rise_cnt = 0;
                    end
                end
                if (temp_valid) begin
                    vtimes.push_back(cyc);
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_valid: got temp_out %0h expected no pulse", temp_out);
                    end else begin
                        last_exp = sb_q.pop_front();
                        check("temp_out", temp_out, last_exp);
                    end
                end
                prev_sck = spi_sck;
                prev_cs  = spi_cs_n;
            end
        end
    end

    // Returns just after the negedge following the n-th pulse, so the
    // monitor has already processed it.
    task automatic wait_valids(input int n, input string name);
        int got    = 0;
        int budget = n * POLL_CYCLES + 400;
        while (got < n && budget > 0) begin
            @(posedge clk);
            #1;
            if (temp_valid) got++;
            budget--;
        end
        check(name, got, n);
        @(negedge clk);
        #1;
    endtask

    // Waits for CS low, then for the n-th rising SCK; returns 1 time unit
    // after the clk edge that raised SCK.
    task automatic wait_rises(input int n, input string name);
        int   cnt    = 0;
        int   budget = 4 * POLL_CYCLES;
        logic prev;
        while (spi_cs_n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        prev = spi_sck;
        while (cnt < n && budget > 0) begin
            @(posedge clk);
            #1;
            if (spi_sck && !prev) cnt++;
            prev = spi_sck;
            budget--;
        end
        check(name, cnt, n);
    endtask

    initial begin
        int lows;
        reset  = 1'b1;
        enable = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sck", spi_sck, 1'b0);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_temp", temp_out, 13'h0);
        check("rst_valid", temp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Known words: +25.0 C and -4.0 C
        plan_q.push_back(16'h0C87);
        plan_q.push_back(16'hFE07);
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        wait_valids(2, "known_frames");

        // Back-to-back period
        vtimes.delete();
        wait_valids(4, "b2b_frames");
        check("b2b_count", vtimes.size(), 4);
        if (vtimes.size() >= 4) begin
            for (int i = 1; i < 4; i++) check("valid_period", vtimes[i] - vtimes[i-1], POLL_CYCLES);
        end

        // Disable mid-frame at 8th rising SCK
        wait_rises(8, "dis_rise_wait");
        enable = 1'b0;
        wait_valids(1, "dis_frame_done");
        lows = 0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (!spi_cs_n) lows++;
        end
        check("no_poll_disabled", lows, 0);
        check("hold_temp", temp_out, last_exp);
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("reenable_cs", spi_cs_n, 1'b0);

        // Reset at 5th rising SCK
        wait_rises(5, "rst_rise_wait");
        reset = 1'b1;
        #1;
        check("midrst_cs_n", spi_cs_n, 1'b1);
        check("midrst_sck", spi_sck, 1'b0);
        check("midrst_temp", temp_out, 13'h0);
        check("midrst_busy", busy, 1'b0);
        sb_q.delete();
        reset_model();
        for (int i = 0; i < 4; i++) plan_q.push_back({13'd400, 3'($urandom)});
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_valids(4, "post_rst_frames");

        // Negative samples from a fresh reset
        repeat (5) @(posedge clk);
        reset = 1'b1;
        sb_q.delete();
        reset_model();
        for (int i = 0; i < 4; i++) plan_q.push_back({13'h1FC0, 3'($urandom)});
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_valids(4, "neg_frames");

        // Random words
        wait_valids(6, "random_frames");

        repeat (5) @(posedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
